vote_logger: RTL and testbench
==============================

Name: vote_logger

Overview:
- Voting-mode front end that turns candidate button levels into vote events and per-candidate tallies.
- Drives the valid-vote pulse and the four 8-bit vote counts consumed by the LED mode/display controller.
- Enforces one vote per press, rejects simultaneous presses, and applies a post-vote lockout before re-arming.

Parameters:
- LOCKOUT_CYCLES, 100, cycles after an accepted vote during which all presses are ignored (>=1).
- COUNT_W, 8, width of each per-candidate tally. Ports are fixed at 8 bits; the only legal value is 8.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = voting, 1 = result display (no counting).
- candidate1_button_pressed_level  input  1  debounced level, high while the button is held.
- candidate2_button_pressed_level  input  1  as above.
- candidate3_button_pressed_level  input  1  as above.
- candidate4_button_pressed_level  input  1  as above.
- valid_vote_casted  output  1  one-cycle pulse on an accepted vote.
- invalid_vote  output  1  one-cycle pulse on a rejected multi-button press.
- candidate1_vote  output  8  saturating tally.
- candidate2_vote  output  8  saturating tally.
- candidate3_vote  output  8  saturating tally.
- candidate4_vote  output  8  saturating tally.
- total_votes  output  10  sum of accepted votes, saturating at 1023.
- busy  output  1  high in LOCKOUT or WAIT_RELEASE.

Behaviour:
- One clock; reset is asynchronous and active-high. All state and outputs are registered.
- Reset values:
  - All tallies, total_votes, valid_vote_casted and invalid_vote = 0.
  - Previous-level register btn_q = 4'b0000; lockout counter = 0.
  - State = WAIT_RELEASE, so a button held through reset never votes. busy = 1 until all buttons are released.
- Edge detection: rise[i] = level[i] & ~btn_q[i]. btn_q is updated every cycle in every state and mode.
- FSM states: IDLE, LOCKOUT, WAIT_RELEASE.
- IDLE, mode=0:
  - Exactly one rise[i], and all other levels low → accept the vote. On that same edge:
    - candidate i tally +1, saturating at 255.
    - total_votes +1, saturating at 1023.
    - valid_vote_casted = 1 for exactly one cycle.
    - Lockout counter loaded with LOCKOUT_CYCLES-1; go to LOCKOUT.
  - Any rise while two or more levels are high → no count change; invalid_vote = 1 for one cycle; go to WAIT_RELEASE.
  - A level high without a rise (already held) → no action.
- IDLE, mode=1: no counting, no pulses. Any level high → go to WAIT_RELEASE.
- LOCKOUT:
  - The counter decrements each cycle; all presses are ignored, with no pulses.
  - When the counter reaches 0, go to WAIT_RELEASE.
  - Total time in LOCKOUT = LOCKOUT_CYCLES cycles.
- WAIT_RELEASE: stay until all four levels are low (sampled), then go to IDLE on the next edge.
- Latency:
  - Level rises before edge k → the tally and valid pulse are visible after edge k.
  - The earliest next accepted vote is at edge k + LOCKOUT_CYCLES + 2, requiring a release then a new press.
- Saturation:
  - A press on a candidate already at 255 is still accepted: valid pulse and total_votes increment; that tally holds at 255.
  - total_votes holds at 1023.
- A mode change mid-LOCKOUT does not abort the lockout. Tallies are never cleared except by reset.
- valid_vote_casted and invalid_vote are never high in the same cycle.

Test Plan:
- Reset, then a 5-cycle press on candidate 2 → candidate2_vote=1, total_votes=1, exactly one valid pulse; busy high for 100 cycles, then until release.
- Candidate 1 press during lockout (30 cycles after the first vote), held past lockout end → no count change; counts only after release and a re-press.
- Candidates 3 and 4 rise on the same edge → invalid_vote pulse, all tallies unchanged, state WAIT_RELEASE until both are released.
- 260 separate candidate-4 votes, each with release and lockout → candidate4_vote=255, total_votes=260, 260 valid pulses.
- mode=1 with a candidate-1 press → no pulses or count change. Switch to mode=0 while still held → no vote until release and re-press.
- Assert reset mid-LOCKOUT with candidate-2 held → all outputs 0 immediately (async), no vote after reset deasserts until release and re-press.

Source files
------------

// File: rtl/vote_logger.sv
// ============================================================================
// Module   : vote_logger
// Purpose  : Voting front end that turns candidate button levels into vote
//            pulses and saturating per-candidate tallies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vote_logger #(
  parameter int LOCKOUT_CYCLES = 100,
  parameter int COUNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               candidate1_button_pressed_level,
  input  logic               candidate2_button_pressed_level,
  input  logic               candidate3_button_pressed_level,
  input  logic               candidate4_button_pressed_level,
  output logic               valid_vote_casted,
  output logic               invalid_vote,
  output logic [COUNT_W-1:0] candidate1_vote,
  output logic [COUNT_W-1:0] candidate2_vote,
  output logic [COUNT_W-1:0] candidate3_vote,
  output logic [COUNT_W-1:0] candidate4_vote,
  output logic [9:0]         total_votes,
  output logic               busy
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] LOCKOUT      = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TALLY_MAX = '1;
  localparam logic [9:0]         TOTAL_MAX = '1;

  logic [3:0]         level;
  logic [3:0]         btn_q;
  logic [3:0]         rise;
  logic [2:0]         level_count;
  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [CNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   lock_cnt_next;
  logic               accept;
  logic               reject;
  logic [COUNT_W-1:0] tally [4];

  assign level = {candidate4_button_pressed_level,
                  candidate3_button_pressed_level,
                  candidate2_button_pressed_level,
                  candidate1_button_pressed_level};

  assign rise = level & ~btn_q;

  assign level_count = {2'b00, level[0]} + {2'b00, level[1]}
                     + {2'b00, level[2]} + {2'b00, level[3]};

  // A rise implies at least one level is high, so one high level means the
  // rising button is the only one pressed.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    accept        = 1'b0;
    reject        = 1'b0;
    case (state)
      IDLE: begin
        if (mode) begin
          if (|level) state_next = WAIT_RELEASE;
        end else if (|rise) begin
          if (level_count == 3'd1) begin
            accept        = 1'b1;
            lock_cnt_next = LOCK_LOAD;
            state_next    = LOCKOUT;
          end else begin
            reject     = 1'b1;
            state_next = WAIT_RELEASE;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt == '0) state_next = WAIT_RELEASE;
        else                lock_cnt_next = lock_cnt - 1'b1;
      end
      WAIT_RELEASE: begin
        if (level == 4'b0000) state_next = IDLE;
      end
      default: state_next = WAIT_RELEASE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= WAIT_RELEASE;
      lock_cnt          <= '0;
      btn_q             <= 4'b0000;
      valid_vote_casted <= 1'b0;
      invalid_vote      <= 1'b0;
      busy              <= 1'b1;
      total_votes       <= '0;
    end else begin
      state             <= state_next;
      lock_cnt          <= lock_cnt_next;
      btn_q             <= level;
      valid_vote_casted <= accept;
      invalid_vote      <= reject;
      busy              <= (state_next != IDLE);
      if (accept && (total_votes != TOTAL_MAX))
        total_votes <= total_votes + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (accept && level[i] && (tally[i] != TALLY_MAX))
          tally[i] <= tally[i] + 1'b1;
    end
  end

  assign candidate1_vote = tally[0];
  assign candidate2_vote = tally[1];
  assign candidate3_vote = tally[2];
  assign candidate4_vote = tally[3];

endmodule

`default_nettype wire

// File: tb/tb_vote_logger.sv
// ============================================================================
// Module   : tb_vote_logger
// Purpose  : Directed self-checking bench for vote_logger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vote_logger;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode  = 1'b0;
  logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0;
  logic       valid_vote_casted, invalid_vote, busy;
  logic [7:0] c1v, c2v, c3v, c4v;
  logic [9:0] total_votes;

  int checks     = 0;
  int failures   = 0;
  int valid_cnt  = 0;
  int invalid_cnt = 0;

  vote_logger #(.LOCKOUT_CYCLES(100), .COUNT_W(8)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .mode                            (mode),
    .candidate1_button_pressed_level (b1),
    .candidate2_button_pressed_level (b2),
    .candidate3_button_pressed_level (b3),
    .candidate4_button_pressed_level (b4),
    .valid_vote_casted               (valid_vote_casted),
    .invalid_vote                    (invalid_vote),
    .candidate1_vote                 (c1v),
    .candidate2_vote                 (c2v),
    .candidate3_vote                 (c3v),
    .candidate4_vote                 (c4v),
    .total_votes                     (total_votes),
    .busy                            (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 300; n++) begin
      if (!busy) break;
      tick();
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_counts(input string tag, input int e1, input int e2,
                              input int e3, input int e4, input int et);
    check({tag, "_c1"}, {24'd0, c1v}, e1);
    check({tag, "_c2"}, {24'd0, c2v}, e2);
    check({tag, "_c3"}, {24'd0, c3v}, e3);
    check({tag, "_c4"}, {24'd0, c4v}, e4);
    check({tag, "_tot"}, {22'd0, total_votes}, et);
  endtask

  // Pulse bookkeeping sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_vote_casted) valid_cnt++;
      if (invalid_vote) invalid_cnt++;
      if (valid_vote_casted && invalid_vote) begin
        failures++;
        $error("FAIL pulse_overlap observed=1 expected=0");
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    check_counts("rst", 0, 0, 0, 0, 0);
    check("rst_valid", {31'd0, valid_vote_casted}, 0);
    check("rst_invalid", {31'd0, invalid_vote}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    tick();
    check("rst_idle", {31'd0, busy}, 0);

    // Candidate 2: five-cycle press, lockout length, then release
    b2 = 1'b1;
    tick();
    check_counts("v2", 0, 1, 0, 0, 1);
    check("v2_valid", {31'd0, valid_vote_casted}, 1);
    check("v2_busy", {31'd0, busy}, 1);
    tick();
    check("v2_valid_one", {31'd0, valid_vote_casted}, 0);
    repeat (3) tick();
    b2 = 1'b0;
    repeat (95) tick();
    check("v2_busy_k99", {31'd0, busy}, 1);
    tick();
    check("v2_busy_k100", {31'd0, busy}, 1);
    tick();
    check("v2_idle_k101", {31'd0, busy}, 0);
    check("v2_pulses", valid_cnt, 1);

    // Candidate 1 pressed during lockout and held past it
    b3 = 1'b1;
    tick();
    check_counts("v3", 0, 1, 1, 0, 2);
    b3 = 1'b0;
    repeat (29) tick();
    b1 = 1'b1;
    repeat (90) tick();
    check_counts("lock_c1", 0, 1, 1, 0, 2);
    check("lock_c1_busy", {31'd0, busy}, 1);
    b1 = 1'b0;
    tick();
    check("lock_c1_rel", {31'd0, busy}, 0);
    b1 = 1'b1;
    tick();
    check_counts("repress_c1", 1, 1, 1, 0, 3);
    check("repress_c1_valid", {31'd0, valid_vote_casted}, 1);
    b1 = 1'b0;
    wait_idle("repress_c1_wait");

    // Simultaneous rise on candidates 3 and 4
    b3 = 1'b1; b4 = 1'b1;
    tick();
    check("dual_invalid", {31'd0, invalid_vote}, 1);
    check("dual_valid", {31'd0, valid_vote_casted}, 0);
    check_counts("dual", 1, 1, 1, 0, 3);
    b3 = 1'b0;
    tick(); tick();
    check("dual_hold_busy", {31'd0, busy}, 1);
    check("dual_invalid_one", {31'd0, invalid_vote}, 0);
    b4 = 1'b0;
    tick();
    check("dual_rel", {31'd0, busy}, 0);

    // 260 candidate-4 votes: tally saturates, total keeps counting
    for (int v = 0; v < 260; v++) begin
      b4 = 1'b1;
      tick();
      b4 = 1'b0;
      tick();
      wait_idle("sat_wait");
    end
    check_counts("sat", 1, 1, 1, 255, 263);
    check("sat_pulses", valid_cnt, 263);

    // Result mode press, then back to voting with the button still held
    mode = 1'b1;
    b1 = 1'b1;
    tick();
    check("mode1_valid", {31'd0, valid_vote_casted}, 0);
    check("mode1_busy", {31'd0, busy}, 1);
    mode = 1'b0;
    repeat (3) tick();
    check_counts("mode1", 1, 1, 1, 255, 263);
    check("mode0_held_busy", {31'd0, busy}, 1);
    b1 = 1'b0;
    tick();
    check("mode0_rel", {31'd0, busy}, 0);
    b1 = 1'b1;
    tick();
    check_counts("mode0_vote", 2, 1, 1, 255, 264);
    b1 = 1'b0;
    wait_idle("mode0_wait");

    // Asynchronous reset mid-lockout with candidate 2 held
    b2 = 1'b1;
    tick();
    check_counts("pre_rst", 2, 2, 1, 255, 265);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check_counts("async_rst", 0, 0, 0, 0, 0);
    check("async_rst_valid", {31'd0, valid_vote_casted}, 0);
    check("async_rst_busy", {31'd0, busy}, 1);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check_counts("post_rst_held", 0, 0, 0, 0, 0);
    check("post_rst_busy", {31'd0, busy}, 1);
    b2 = 1'b0;
    tick();
    check("post_rst_rel", {31'd0, busy}, 0);
    b2 = 1'b1;
    tick();
    check_counts("post_rst_vote", 0, 1, 0, 0, 1);
    check("post_rst_valid", {31'd0, valid_vote_casted}, 1);
    b2 = 1'b0;
    tick(); tick();

    check("final_valid_pulses", valid_cnt, 266);
    check("final_invalid_pulses", invalid_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
